// File: rtl/sumador_4bit.sv
// 4-bit ripple-carry adder with combinational and registered sum/carry outputs.
// Optional signed-overflow outputs Ovf/Ovf_r are built when SUMADOR_4BIT_OVF_EN is defined.
module sumador_4bit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [3:0] Sum,
   output logic       Cout,
   output logic [3:0] Sum_r,
   output logic       Cout_r
`ifdef SUMADOR_4BIT_OVF_EN
   ,
   output logic       Ovf,
   output logic       Ovf_r
`endif
);

   logic [4:0] carry_s;
   logic [3:0] sum_d;
   logic [3:0] sum_q;
   logic       cout_d;
   logic       cout_q;

   assign carry_s[0] = 1'b0;

   // One full-adder cell per bit; carries ripple from bit 0 upward.
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign Sum[i]         = A[i] ^ B[i] ^ carry_s[i];
      assign carry_s[i + 1] = (A[i] & B[i]) | (carry_s[i] & (A[i] ^ B[i]));
   end

   assign Cout = carry_s[4];

   // Next-state for the result stage; reset is sampled synchronously.
   always_comb begin
      sum_d  = 4'd0;
      cout_d = 1'b0;
      if (rst_n) begin
         sum_d  = Sum;
         cout_d = Cout;
      end else begin
         sum_d  = 4'd0;
         cout_d = 1'b0;
      end
   end

   // Result stage register.
   always_ff @(posedge clk) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
   end

   assign Sum_r  = sum_q;
   assign Cout_r = cout_q;

`ifdef SUMADOR_4BIT_OVF_EN
   logic ovf_d;
   logic ovf_q;

   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign Ovf = carry_s[3] ^ carry_s[4];

   // Next-state for the overflow flag, same reset behaviour as the sum stage.
   always_comb begin
      ovf_d = 1'b0;
      if (rst_n) begin
         ovf_d = Ovf;
      end else begin
         ovf_d = 1'b0;
      end
   end

   // Overflow flag register.
   always_ff @(posedge clk) begin
      ovf_q <= ovf_d;
   end

   assign Ovf_r = ovf_q;
`endif

endmodule

// File: tb/tb_sumador_4bit.sv
// Self-checking bench for sumador_4bit: exhaustive combinational sweep plus a
// scoreboard for the registered stage; covers the overflow outputs when SUMADOR_4BIT_OVF_EN is defined.
module tb_sumador_4bit;

`ifdef SUMADOR_4BIT_OVF_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] A;
   logic [3:0] B;
   logic [3:0] Sum;
   logic       Cout;
   logic [3:0] Sum_r;
   logic       Cout_r;
   logic       ovf_s;
   logic       ovf_r_s;

   int n_vec = 0;
   int n_err = 0;
   logic [5:0] sb_q[$];
   logic [5:0] hold_v;

   always #5 clk = ~clk;

   sumador_4bit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .A      (A),
      .B      (B),
      .Sum    (Sum),
      .Cout   (Cout),
      .Sum_r  (Sum_r),
      .Cout_r (Cout_r)
`ifdef SUMADOR_4BIT_OVF_EN
      ,
      .Ovf    (ovf_s),
      .Ovf_r  (ovf_r_s)
`endif
   );

`ifndef SUMADOR_4BIT_OVF_EN
   assign ovf_s   = 1'b0;
   assign ovf_r_s = 1'b0;
`endif

   // Reference: {ovf, cout, sum[3:0]} from plain integer arithmetic.
   function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      logic       v;
      s = {1'b0, a} + {1'b0, b};
      v = (a[3] == b[3]) && (s[3] != a[3]);
      return {OVF_EN & v, s};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] comb_obs();
      return {2'b00, ovf_s, Cout, Sum};
   endfunction

   function automatic logic [7:0] reg_obs();
      return {2'b00, ovf_r_s, Cout_r, Sum_r};
   endfunction

   // Drive operands on the falling edge and queue the value the next edge must capture.
   task automatic drive_push(input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      A = a;
      B = b;
      sb_q.push_back(model(a, b));
   endtask

   task automatic edge_pop(input string tag);
      logic [5:0] e;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL %s: observed empty scoreboard expected entry", tag);
      end else begin
         e = sb_q.pop_front();
         hold_v = e;
         check(tag, reg_obs(), {2'b00, e});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      A = 4'd5;
      B = 4'd6;
      @(posedge clk);
      #1;
      check("reset_regs", reg_obs(), 8'h00);
      check("comb_in_reset", comb_obs(), {2'b00, model(4'd5, 4'd6)});

      // Exhaustive combinational sweep; registers stay in reset meanwhile.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            A = a[3:0];
            B = b[3:0];
            #5;
            check("exhaustive", comb_obs(), {2'b00, model(a[3:0], b[3:0])});
         end
      end
      check("regs_held_reset", reg_obs(), 8'h00);

      A = 4'd15; B = 4'd1;  #5; check("wrap_15p1",  {3'b000, Cout, Sum}, 8'h10);
      A = 4'd15; B = 4'd15; #5; check("wrap_15p15", {3'b000, Cout, Sum}, 8'h1E);
      A = 4'd0;  B = 4'd0;  #5; check("zero_0p0",   {3'b000, Cout, Sum}, 8'h00);
      A = 4'd3;  B = 4'd4;  #5; check("add_3p4",    {3'b000, Cout, Sum}, 8'h07);

      // Latency: 9+8 applied before an edge, visible only after it.
      @(negedge clk);
      rst_n = 1'b1;
      A = 4'd9;
      B = 4'd8;
      sb_q.push_back(model(4'd9, 4'd8));
      #3;
      check("lat_before_edge", {3'b000, Cout_r, Sum_r}, 8'h00);
      check("lat_comb", {3'b000, Cout, Sum}, 8'h11);
      edge_pop("lat_after_edge");
      check("lat_value", {3'b000, Cout_r, Sum_r}, 8'h11);

      // Random vectors; operands change right after each edge must not disturb registers.
      for (int k = 0; k < 20; k++) begin
         drive_push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         edge_pop("rand_reg");
         A = ~A;
         #2;
         check("midcycle_hold", reg_obs(), {2'b00, hold_v});
         check("midcycle_comb", comb_obs(), {2'b00, model(A, B)});
      end

      // Reset asserted mid-cycle: registered outputs wait for the edge.
      drive_push(4'd9, 4'd8);
      edge_pop("pre_reset_val");
      @(negedge clk);
      rst_n = 1'b0;
      A = 4'd2;
      B = 4'd3;
      #1;
      check("rst_midcycle_hold", reg_obs(), {2'b00, hold_v});
      check("rst_comb_track", comb_obs(), {2'b00, model(4'd2, 4'd3)});
      @(posedge clk);
      #1;
      check("rst_after_edge", reg_obs(), 8'h00);
      A = 4'd12;
      B = 4'd7;
      #1;
      check("rst_comb_track2", comb_obs(), {2'b00, model(4'd12, 4'd7)});

      // First edge after release captures the current operands.
      @(negedge clk);
      rst_n = 1'b1;
      sb_q.push_back(model(4'd12, 4'd7));
      edge_pop("release_capture");

`ifdef SUMADOR_4BIT_OVF_EN
      A = 4'd7;  B = 4'd1;  #1; check("ovf_7p1",  comb_obs(), 8'h28);
      A = 4'd8;  B = 4'd8;  #1; check("ovf_8p8",  comb_obs(), 8'h30);
      A = 4'd15; B = 4'd1;  #1; check("ovf_15p1", comb_obs(), 8'h10);
      drive_push(4'd7, 4'd1);
      edge_pop("ovf_r_7p1");
      drive_push(4'd8, 4'd8);
      edge_pop("ovf_r_8p8");
      drive_push(4'd15, 4'd1);
      edge_pop("ovf_r_15p1");
`endif

      if (sb_q.size() != 0) begin
         n_vec++;
         n_err++;
         $error("FAIL sb_drain: observed %0d leftover expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
